// File: rtl/reg_file_paged.sv
// reg_file_paged: paged-PC register file with a stalling load handshake,
// literal shift-in and clamped funnel shifts.
module reg_file_paged #(
   parameter int DATA_W     = 8,
   parameter int NUM_REGS   = 16,
   parameter int PAGE_W     = 2,
   parameter int LD_TIMEOUT = 15,
   parameter int A_IDX      = 8,
   parameter int B_IDX      = 9
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        en,
   input  logic [3:0]                  op,
   input  logic [$clog2(NUM_REGS)-1:0] src,
   input  logic [$clog2(NUM_REGS)-1:0] dst,
   input  logic [3:0]                  imm,
   input  logic [DATA_W-1:0]           ld_data,
   input  logic                        ld_valid,
   output logic                        ld_req,
   output logic                        stall,
   output logic [DATA_W-1:0]           st_data,
   output logic                        st_valid,
   output logic                        ld_err,
   output logic [PAGE_W+DATA_W-1:0]    pc,
   output logic [DATA_W-1:0]           a_o,
   output logic [DATA_W-1:0]           b_o
);
   localparam int AW = $clog2(NUM_REGS);
   localparam int TW = $clog2(LD_TIMEOUT + 1);
   localparam logic [AW-1:0] PC  = AW'(NUM_REGS - 1);
   localparam logic [AW-1:0] TGT = AW'(NUM_REGS - 2);
   localparam logic [AW-1:0] LIT = AW'(NUM_REGS - 3);

   typedef enum logic {IDLE, WAIT_LD} state_t;
   state_t state, state_nx;

   logic [DATA_W-1:0]   regs [NUM_REGS];
   logic [PAGE_W-1:0]   page, page_nx;
   logic [TW-1:0]       timer;
   logic [AW-1:0]       ld_dst, widx;
   logic [DATA_W-1:0]   rs, rp, pc_inc, pc_nx, wval, msk;
   logic [2*DATA_W-1:0] shl, shr;
   logic [31:0]         k;
   logic                we, tmo, store;

   assign rs     = regs[src];
   assign rp     = regs[src ^ AW'(1)];
   assign pc_inc = regs[PC] + DATA_W'(1);
   assign k      = 32'(imm) > 32'(DATA_W) ? 32'(DATA_W) : 32'(imm);
   assign shl    = {rs, rp} << k;
   assign shr    = {rp, rs} >> k;
   assign msk    = 32'(imm) < 32'(DATA_W) ? DATA_W'(1) << imm : '0;
   assign tmo    = state == WAIT_LD && !ld_valid && timer == TW'(LD_TIMEOUT - 1);
   assign store  = state == IDLE && en && op == 4'd4;
   assign pc     = {page, regs[PC]};
   assign a_o    = regs[A_IDX];
   assign b_o    = regs[B_IDX];

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;

   // Writes aimed at PC are dropped at commit; only pc_nx ever changes it.
   always_comb begin
      state_nx = state;
      we       = 1'b0;
      widx     = src;
      wval     = rs;
      pc_nx    = regs[PC];
      page_nx  = page;
      if (state == WAIT_LD) begin
         if (ld_valid || tmo) begin
            state_nx = IDLE;
            we       = 1'b1;
            widx     = ld_dst;
            wval     = ld_valid ? ld_data : '0;
            pc_nx    = pc_inc;
         end
      end else if (en) begin
         pc_nx = pc_inc;
         case (op)
            4'd1:  begin we = 1'b1; widx = LIT; wval = (regs[LIT] << 4) | DATA_W'(imm); end
            4'd2:  begin
               we    = 1'b1;
               widx  = dst;
               wval  = src == dst ? '0 : rs;
               pc_nx = dst == PC ? wval : pc_inc;
            end
            4'd3:  begin state_nx = WAIT_LD; pc_nx = regs[PC]; end
            4'd5:  begin we = 1'b1; wval = rs + DATA_W'(1); end
            4'd6:  begin we = 1'b1; wval = rs - DATA_W'(1); end
            4'd7:  pc_nx = rs == '0 ? regs[TGT] : pc_inc;
            4'd8:  pc_nx = rs != '0 ? regs[TGT] : pc_inc;
            4'd9:  begin we = 1'b1; wval = rs | msk; end
            4'd10: begin we = 1'b1; wval = rs ^ msk; end
            4'd11: begin we = 1'b1; wval = shl[2*DATA_W-1:DATA_W]; end
            4'd12: begin we = 1'b1; wval = shr[DATA_W-1:0]; end
            4'd13: begin page_nx = imm[PAGE_W-1:0]; pc_nx = regs[TGT]; end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
         page     <= '0;
         timer    <= '0;
         ld_dst   <= '0;
         ld_req   <= 1'b0;
         stall    <= 1'b0;
         st_data  <= '0;
         st_valid <= 1'b0;
         ld_err   <= 1'b0;
      end else begin
         page     <= page_nx;
         regs[PC] <= pc_nx;
         if (we && widx != PC) regs[widx] <= wval;
         timer    <= state == WAIT_LD ? timer + TW'(1) : '0;
         if (state == IDLE && state_nx == WAIT_LD) ld_dst <= dst;
         ld_req   <= state_nx == WAIT_LD;
         stall    <= state_nx == WAIT_LD;
         st_valid <= store;
         if (store) st_data <= rs;
         ld_err   <= ld_err | tmo;
      end
endmodule

// File: tb/tb_reg_file_paged.sv
// tb_reg_file_paged: directed plus random ops against an arithmetic model,
// expectations queued per cycle and compared by an independent monitor.
module tb_reg_file_paged;
   localparam int DW = 8, NR = 16, PW = 2, TO = 15, AI = 8, BI = 9;
   localparam int M = 1 << DW, PCI = NR - 1, TGT = NR - 2, LIT = NR - 3;

   logic          clk = 1'b0, rst_n = 1'b0, en = 1'b0, ld_valid = 1'b0;
   logic [3:0]    op = '0, imm = '0, src = '0, dst = '0;
   logic [DW-1:0] ld_data = '0;
   logic          ld_req, stall, st_valid, ld_err;
   logic [DW-1:0] st_data, a_o, b_o;
   logic [PW+DW-1:0] pc;

   reg_file_paged #(.DATA_W(DW), .NUM_REGS(NR), .PAGE_W(PW), .LD_TIMEOUT(TO),
                    .A_IDX(AI), .B_IDX(BI)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .op(op), .src(src), .dst(dst), .imm(imm),
      .ld_data(ld_data), .ld_valid(ld_valid), .ld_req(ld_req), .stall(stall),
      .st_data(st_data), .st_valid(st_valid), .ld_err(ld_err), .pc(pc),
      .a_o(a_o), .b_o(b_o));

   always #5 clk = ~clk;

   typedef struct {int due; int pc; int a; int b; bit sv; int sd; bit st; bit err;} exp_t;
   exp_t q[$];
   int   r[NR];
   int   page, sd, cyc, vec, bad;
   bit   err, sv_m;

   always @(posedge clk) cyc++;

   task automatic chk(string n, logic [31:0] act, logic [31:0] req);
      vec++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", n, cyc, act, req);
      end
   endtask

   always @(negedge clk)
      if (q.size() > 0 && q[0].due <= cyc) begin
         exp_t e;
         e = q.pop_front();
         chk("pc", 32'(pc), e.pc);
         chk("a_o", 32'(a_o), e.a);
         chk("b_o", 32'(b_o), e.b);
         chk("st_valid", 32'(st_valid), 32'(e.sv));
         chk("st_data", 32'(st_data), e.sd);
         chk("stall", 32'(stall), 32'(e.st));
         chk("ld_req", 32'(ld_req), 32'(e.st));
         chk("ld_err", 32'(ld_err), 32'(e.err));
      end

   function automatic void push(int due, bit st);
      exp_t e;
      e.due = due; e.pc = page * M + r[PCI]; e.a = r[AI]; e.b = r[BI];
      e.sv = sv_m; e.sd = sd; e.st = st; e.err = err;
      q.push_back(e);
      sv_m = 1'b0;
   endfunction

   function automatic void model_reset();
      foreach (r[i]) r[i] = 0;
      page = 0; sd = 0; err = 1'b0; sv_m = 1'b0;
      q.delete();
   endfunction

   // Reference behaviour for every single-cycle op.
   function automatic void exec(int o, int s, int d, int im);
      int rs, wi, wv, k;
      bit inc;
      rs = r[s]; wi = -1; wv = 0; inc = 1'b1;
      k = im > DW ? DW : im;
      case (o)
         1: begin wi = LIT; wv = (r[LIT] * 16 + im) % M; end
         2: if (d == PCI) begin r[PCI] = (s == d) ? 0 : rs; inc = 1'b0; end
            else begin wi = d; wv = (s == d) ? 0 : rs; end
         4: begin sd = rs; sv_m = 1'b1; end
         5: begin wi = s; wv = (rs + 1) % M; end
         6: begin wi = s; wv = (rs + M - 1) % M; end
         7: if (rs == 0) begin r[PCI] = r[TGT]; inc = 1'b0; end
         8: if (rs != 0) begin r[PCI] = r[TGT]; inc = 1'b0; end
         9: begin wi = s; wv = im < DW ? rs | (1 << im) : rs; end
         10: begin wi = s; wv = im < DW ? rs ^ (1 << im) : rs; end
         11: begin wi = s; wv = k == 0 ? rs : ((rs << k) | (r[s ^ 1] >> (DW - k))) % M; end
         12: begin wi = s; wv = k == 0 ? rs : ((rs >> k) | (r[s ^ 1] << (DW - k))) % M; end
         13: begin page = im % (1 << PW); r[PCI] = r[TGT]; inc = 1'b0; end
         default: ;
      endcase
      if (wi >= 0 && wi != PCI) r[wi] = wv;
      if (inc) r[PCI] = (r[PCI] + 1) % M;
   endfunction

   // Called just after a posedge; returns just after the op's final posedge.
   task automatic issue(int o, int s, int d, int im, int dly = 1, int data = 0);
      int w;
      en = 1'b1; op = 4'(o); src = 4'(s); dst = 4'(d); imm = 4'(im);
      ld_data = DW'($urandom);
      sv_m = 1'b0;
      if (o != 3) begin
         ld_valid = 1'($urandom_range(0, 1));
         exec(o, s, d, im);
         push(cyc + 1, 1'b0);
         @(posedge clk); #1;
      end else begin
         ld_valid = 1'b0;
         w = dly < TO ? dly : TO;
         for (int i = 1; i <= w; i++) push(cyc + i, 1'b1);
         if (d != PCI) r[d] = dly <= TO ? data : 0;
         if (dly > TO) err = 1'b1;
         r[PCI] = (r[PCI] + 1) % M;
         push(cyc + w + 1, 1'b0);
         @(posedge clk); #1;
         for (int i = 1; i <= w; i++) begin
            if (i == dly) begin ld_valid = 1'b1; ld_data = DW'(data); end
            @(posedge clk); #1;
            ld_valid = 1'b0;
         end
      end
      en = 1'b0; ld_valid = 1'b0;
   endtask

   task automatic idle();
      en = 1'b0; op = 4'($urandom); ld_valid = 1'($urandom_range(0, 1));
      push(cyc + 1, 1'b0);
      @(posedge clk); #1;
      ld_valid = 1'b0;
   endtask

   task automatic chk_zero(string n);
      chk({n, "_pc"}, 32'(pc), 0);
      chk({n, "_ab"}, {16'(a_o), 16'(b_o)}, 0);
      chk({n, "_flags"}, {28'(0), stall, ld_req, st_valid, ld_err}, 0);
      chk({n, "_st_data"}, 32'(st_data), 0);
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1 chk_zero("reset");
      rst_n = 1'b1;
      issue(1, 0, 0, 4'hA);
      issue(1, 0, 0, 4'h5);
      issue(2, LIT, AI, 0);
      // load in flight when reset hits: aborted with nothing written
      en = 1'b1; op = 4'd3; dst = 4'(AI);
      @(posedge clk); #1 en = 1'b0;
      chk("stall_mid_load", 32'(stall), 1);
      #2 rst_n = 1'b0;
      #1 chk_zero("async_reset");
      model_reset();
      @(posedge clk); #1 rst_n = 1'b1;
      issue(3, 0, TGT, 0, 1, 8'h40);
      issue(7, 2, 0, 0);
      issue(8, 2, 0, 0);
      issue(13, 0, 0, 3);
      issue(3, 0, TGT, 0, 2, 8'hFF);
      issue(7, 2, 0, 0);
      issue(6, PCI, 0, 0);
      issue(3, 0, AI, 0, 3, 8'hC3);
      issue(3, 0, AI, 0, TO + 5);
      issue(3, 0, AI, 0, TO, 8'h77);
      issue(3, 0, 4, 0, 1, 8'hB1);
      issue(3, 0, 5, 0, 1, 8'h6E);
      issue(11, 4, 0, 3);
      issue(2, 4, AI, 0);
      issue(3, 0, 4, 0, 1, 8'hB1);
      issue(12, 5, 0, 12);
      issue(2, 5, BI, 0);
      issue(2, 6, 6, 0);
      issue(5, PCI, 0, 0);
      issue(9, 7, 0, 9);
      issue(10, 7, 0, 7);
      issue(2, 7, AI, 0);
      issue(3, 0, BI, 0, 1, 8'h3C);
      issue(4, BI, 0, 0);
      repeat (4) idle();
      issue(4, PCI, 0, 0);
      for (int i = 0; i < 400; i++)
         if ($urandom_range(0, 7) == 0) idle();
         else issue($urandom_range(0, 15), $urandom_range(0, NR - 1), $urandom_range(0, NR - 1),
                    $urandom_range(0, 15), $urandom_range(1, TO + 2), $urandom_range(0, M - 1));
      repeat (3) @(negedge clk);
      chk("queue_drained", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, %0d expectations pending", q.size());
      $fatal(1, "watchdog");
   end
endmodule
